// File: rtl/riscv_pkg.sv
// Shared RISC-V widths and the load funct3 encoding used by the writeback path.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks byte/halfword from an aligned word and extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = off[1] ? data[31:16] : data[15:0];
  end

  // Reserved encodings (011/110/111) fall through to a full-word load.
  always_comb begin
    result = data;
    case (funct3)
      LD_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: merges load responses and execute results into one register-file
// write port with a one-entry hold buffer. Define WB_BYPASS_EN to enable forwarding.
module writeback_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [XLEN-1:0]       ex_result,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd_addr,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_off,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_fwd_valid,
  output logic                  rs2_fwd_valid,
  output logic [XLEN-1:0]       rs1_fwd,
  output logic [XLEN-1:0]       rs2_fwd,
  output logic                  pending_hit
);

  logic                  write_q, write_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_q, rd_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [REG_ADDR_W-1:0] hold_rd_q, hold_rd_d;
  logic [XLEN-1:0]       hold_data_q, hold_data_d;

  logic [XLEN-1:0] ld_value;
  logic            ex_fire;

  load_align u_load_align (
    .funct3 (ld_funct3),
    .off    (ld_off),
    .data   (ld_data),
    .result (ld_value)
  );

  assign ex_ready = rst_n && !hold_valid_q;
  assign ex_fire  = ex_valid && ex_ready;

  // Priority load > hold > execute; x0 destinations are accepted but never written.
  always_comb begin
    write_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_d         = rd_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    if (ld_valid) begin
      if (ld_rd_addr != '0) begin
        write_d   = 1'b1;
        rd_addr_d = ld_rd_addr;
        rd_d      = ld_value;
      end
      if (ex_fire && ex_rd_addr != '0) begin
        hold_valid_d = 1'b1;
        hold_rd_d    = ex_rd_addr;
        hold_data_d  = ex_result;
      end
    end else if (hold_valid_q) begin
      write_d      = 1'b1;
      rd_addr_d    = hold_rd_q;
      rd_d         = hold_data_q;
      hold_valid_d = 1'b0;
    end else if (ex_fire && ex_rd_addr != '0) begin
      write_d   = 1'b1;
      rd_addr_d = ex_rd_addr;
      rd_d      = ex_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
    end else begin
      write_q      <= write_d;
      rd_addr_q    <= rd_addr_d;
      rd_q         <= rd_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign write   = write_q;
  assign rd_addr = rd_addr_q;
  assign rd      = rd_q;

  assign pending_hit = hold_valid_q && (hold_rd_q != '0) &&
                       ((hold_rd_q == rs1_addr) || (hold_rd_q == rs2_addr));

`ifdef WB_BYPASS_EN
  assign rs1_fwd_valid = write_q && (rd_addr_q == rs1_addr) && (rs1_addr != '0);
  assign rs2_fwd_valid = write_q && (rd_addr_q == rs2_addr) && (rs2_addr != '0);
  assign rs1_fwd       = rd_q;
  assign rs2_fwd       = rd_q;
`else
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd       = '0;
  assign rs2_fwd       = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage plus hand sequences for hold/reset cases.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_result;
  logic        ld_valid;
  logic [4:0]  ld_rd_addr;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        write;
  logic [4:0]  rd_addr;
  logic [31:0] rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd, rs2_fwd;
  logic        pending_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_addr(ex_rd_addr), .ex_result(ex_result),
    .ld_valid(ld_valid), .ld_rd_addr(ld_rd_addr), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_off(ld_off),
    .write(write), .rd_addr(rd_addr), .rd(rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .pending_hit(pending_hit)
  );

  typedef struct {
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] ld_d;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        ex_v;
    logic [4:0]  ex_rd;
    logic [31:0] ex_d;
    logic        exp_wr;
    logic [4:0]  exp_rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%08h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd_addr = 0; ex_result = 0;
    ld_valid = 0; ld_rd_addr = 0; ld_data = 0; ld_funct3 = 3'b010; ld_off = 0;
  endtask

  initial begin
    vecs[0]  = '{1, 5'd5,  32'h0000_80FF, 3'b000, 2'd1, 0, 5'd0,  32'h0,         1, 5'd5,  32'hFFFF_FF80};
    vecs[1]  = '{1, 5'd6,  32'h0000_80FF, 3'b100, 2'd1, 0, 5'd0,  32'h0,         1, 5'd6,  32'h0000_0080};
    vecs[2]  = '{1, 5'd7,  32'h8001_1234, 3'b001, 2'd2, 0, 5'd0,  32'h0,         1, 5'd7,  32'hFFFF_8001};
    vecs[3]  = '{1, 5'd8,  32'h8001_1234, 3'b101, 2'd2, 0, 5'd0,  32'h0,         1, 5'd8,  32'h0000_8001};
    vecs[4]  = '{1, 5'd9,  32'hCAFE_BABE, 3'b010, 2'd3, 0, 5'd0,  32'h0,         1, 5'd9,  32'hCAFE_BABE};
    vecs[5]  = '{1, 5'd10, 32'h1234_5678, 3'b011, 2'd1, 0, 5'd0,  32'h0,         1, 5'd10, 32'h1234_5678};
    vecs[6]  = '{1, 5'd11, 32'h7F00_0000, 3'b000, 2'd3, 0, 5'd0,  32'h0,         1, 5'd11, 32'h0000_007F};
    vecs[7]  = '{0, 5'd0,  32'h0,         3'b010, 2'd0, 1, 5'd12, 32'hA5A5_A5A5, 1, 5'd12, 32'hA5A5_A5A5};
    vecs[8]  = '{0, 5'd0,  32'h0,         3'b010, 2'd0, 1, 5'd0,  32'h0000_DEAD, 0, 5'd12, 32'hA5A5_A5A5};
    vecs[9]  = '{1, 5'd0,  32'h5555_5555, 3'b010, 2'd0, 0, 5'd0,  32'h0,         0, 5'd12, 32'hA5A5_A5A5};
    vecs[10] = '{1, 5'd13, 32'h0000_FFFE, 3'b001, 2'd0, 0, 5'd0,  32'h0,         1, 5'd13, 32'hFFFF_FFFE};
    vecs[11] = '{0, 5'd0,  32'h0,         3'b010, 2'd0, 0, 5'd0,  32'h0,         0, 5'd13, 32'hFFFF_FFFE};

    idle_inputs();
    rs1_addr = 0; rs2_addr = 0;
    rst_n = 0;
    step(); step();
    chk("reset_write", {31'b0, write}, 32'd0);
    chk("reset_rd_addr", {27'b0, rd_addr}, 32'd0);
    chk("reset_rd", rd, 32'd0);
    chk("reset_ex_ready", {31'b0, ex_ready}, 32'd0);
    rst_n = 1;
    #1;
    chk("post_reset_ex_ready", {31'b0, ex_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      ld_valid = vecs[i].ld_v; ld_rd_addr = vecs[i].ld_rd; ld_data = vecs[i].ld_d;
      ld_funct3 = vecs[i].f3; ld_off = vecs[i].off;
      ex_valid = vecs[i].ex_v; ex_rd_addr = vecs[i].ex_rd; ex_result = vecs[i].ex_d;
      step();
      idle_inputs();
      chk($sformatf("vec%0d_write", i), {31'b0, write}, {31'b0, vecs[i].exp_wr});
      chk($sformatf("vec%0d_rd_addr", i), {27'b0, rd_addr}, {27'b0, vecs[i].exp_rd_addr});
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_ex_ready", i), {31'b0, ex_ready}, 32'd1);
    end

    // Load and execute in the same cycle: execute result is parked in hold.
    ld_valid = 1; ld_rd_addr = 5'd3; ld_data = 32'h11; ld_funct3 = 3'b010;
    ex_valid = 1; ex_rd_addr = 5'd4; ex_result = 32'h22;
    step();
    idle_inputs();
    chk("dual_c1_write", {31'b0, write}, 32'd1);
    chk("dual_c1_rd_addr", {27'b0, rd_addr}, 32'd3);
    chk("dual_c1_rd", rd, 32'h11);
    chk("dual_c1_ex_ready", {31'b0, ex_ready}, 32'd0);
    step();
    chk("dual_c2_write", {31'b0, write}, 32'd1);
    chk("dual_c2_rd_addr", {27'b0, rd_addr}, 32'd4);
    chk("dual_c2_rd", rd, 32'h22);
    step();
    chk("dual_c3_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("dual_c3_write", {31'b0, write}, 32'd0);

    // Forwarding from the output register.
    ex_valid = 1; ex_rd_addr = 5'd7; ex_result = 32'h1234;
    step();
    idle_inputs();
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    #1;
`ifdef WB_BYPASS_EN
    chk("fwd_rs1_valid", {31'b0, rs1_fwd_valid}, 32'd1);
    chk("fwd_rs1_data", rs1_fwd, 32'h1234);
`else
    chk("fwd_rs1_valid", {31'b0, rs1_fwd_valid}, 32'd0);
    chk("fwd_rs1_data", rs1_fwd, 32'h0);
`endif
    chk("fwd_rs2_valid", {31'b0, rs2_fwd_valid}, 32'd0);
    rs1_addr = 0;
    step();

    // Park x9 in hold, starve it with a second load, then reset before it drains.
    ld_valid = 1; ld_rd_addr = 5'd1; ld_data = 32'hAAAA; ld_funct3 = 3'b010;
    ex_valid = 1; ex_rd_addr = 5'd9; ex_result = 32'h9999;
    step();
    ex_valid = 0; ex_rd_addr = 0; ex_result = 0;
    ld_rd_addr = 5'd2; ld_data = 32'hBBBB;
    rs2_addr = 5'd9;
    #1;
    chk("hold_pending_hit", {31'b0, pending_hit}, 32'd1);
    chk("hold_ex_ready", {31'b0, ex_ready}, 32'd0);
    step();
    chk("starve_rd_addr", {27'b0, rd_addr}, 32'd2);
    chk("starve_pending_hit", {31'b0, pending_hit}, 32'd1);
    idle_inputs();
    rst_n = 0;
    step();
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_rd_addr", {27'b0, rd_addr}, 32'd0);
    chk("rst_pending_hit", {31'b0, pending_hit}, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_write", i), {31'b0, write}, 32'd0);
    end
    chk("post_rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("post_rst_pending_hit", {31'b0, pending_hit}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
